// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit for the EX stage of the pipelined MIPS core.
// It owns the HI/LO registers and executes mult/multu/div/divu/mthi/mtlo.
// mfhi/mflo are served combinationally on md_out.
// Multi-cycle latency is modelled with a busy counter. Results are computed
// when the operation is accepted, held in pending registers, and committed
// to HI/LO on the cycle Busy falls.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-high reset
//   Src1   - rs operand (32)
//   Src2   - rt operand (32)
//   MDOP   - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//            7 mfhi, 8 mflo, 9-15 none
//   Start  - MD instruction valid in EX this cycle
//   Flush  - exception flush of EX this cycle, suppresses Start
//   Busy   - registered, high while a mult/div is in flight
//   HI, LO - registered HI/LO
//   MDOut  - HI when MDOP=7, LO when MDOP=8, else 0
//
// Handshake: an operation is accepted at a rising edge when
// Start & ~Flush & ~Busy and MDOP is in 1..6. Start is ignored while Busy is high.
// There is no back-pressure beyond Busy.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Src1,
    input  logic [31:0] Src2,
    input  logic [3:0]  MDOP,
    input  logic        Start,
    input  logic        Flush,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDOut
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        pend_hi;
    logic [31:0]        pend_lo;
    logic               pend_wr;   // cleared for divide by zero: HI/LO untouched

    logic               accept;

    // Arithmetic results, all computed from the operands at the accept edge.
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        divisor_safe;
    logic [31:0]        uq, ur;       // unsigned quotient/remainder
    logic [31:0]        mag_a, mag_b; // magnitudes for signed divide
    logic [31:0]        mq, mr;
    logic [31:0]        sq, sr;       // signed quotient/remainder

    assign accept = Start & ~Flush & ~Busy;

    always_comb begin
        prod_s       = $signed(Src1) * $signed(Src2);
        prod_u       = {32'd0, Src1} * {32'd0, Src2};
        // A zero divisor is replaced so the divider never sees it; the
        // result is discarded through pend_wr anyway.
        divisor_safe = (Src2 == 32'd0) ? 32'd1 : Src2;
        uq           = Src1 / divisor_safe;
        ur           = Src1 % divisor_safe;
        // Signed divide done on magnitudes so 0x80000000 / -1 wraps to
        // 0x80000000 without relying on simulator overflow behaviour.
        mag_a        = Src1[31] ? (~Src1 + 32'd1) : Src1;
        mag_b        = divisor_safe[31] ? (~divisor_safe + 32'd1) : divisor_safe;
        mq           = mag_a / mag_b;
        mr           = mag_a % mag_b;
        sq           = (Src1[31] ^ divisor_safe[31]) ? (~mq + 32'd1) : mq;
        sr           = Src1[31] ? (~mr + 32'd1) : mr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
            Busy    <= 1'b0;
            HI      <= '0;
            LO      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (MDOP)
                            4'd1: begin
                                pend_hi <= prod_s[63:32];
                                pend_lo <= prod_s[31:0];
                                pend_wr <= 1'b1;
                                cnt     <= CNT_W'(MULT_CYCLES);
                                state   <= RUN;
                                Busy    <= 1'b1;
                            end
                            4'd2: begin
                                pend_hi <= prod_u[63:32];
                                pend_lo <= prod_u[31:0];
                                pend_wr <= 1'b1;
                                cnt     <= CNT_W'(MULT_CYCLES);
                                state   <= RUN;
                                Busy    <= 1'b1;
                            end
                            4'd3: begin
                                pend_hi <= sr;
                                pend_lo <= sq;
                                pend_wr <= (Src2 != 32'd0);
                                cnt     <= CNT_W'(DIV_CYCLES);
                                state   <= RUN;
                                Busy    <= 1'b1;
                            end
                            4'd4: begin
                                pend_hi <= ur;
                                pend_lo <= uq;
                                pend_wr <= (Src2 != 32'd0);
                                cnt     <= CNT_W'(DIV_CYCLES);
                                state   <= RUN;
                                Busy    <= 1'b1;
                            end
                            4'd5:    HI <= Src1;
                            4'd6:    LO <= Src1;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // Flush is deliberately not consulted here: the in-flight
                    // instruction is older than any faulting one.
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                        if (pend_wr) begin
                            HI <= pend_hi;
                            LO <= pend_lo;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        MDOut = 32'd0;
        if (MDOP == 4'd7)
            MDOut = HI;
        else if (MDOP == 4'd8)
            MDOut = LO;
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Src1;
    logic [31:0] Src2;
    logic [3:0]  MDOP;
    logic        Start;
    logic        Flush;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDOut;

    int checks   = 0;
    int failures = 0;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .Src1  (Src1),
        .Src2  (Src2),
        .MDOP  (MDOP),
        .Start (Start),
        .Flush (Flush),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO),
        .MDOut (MDOut)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue a mult/div at edge 0, check Busy and unchanged HI/LO after
    // edges 0..n-1, then check the committed result after edge n.
    // Operands are scrambled after the accept edge.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int n,
                          input logic [31:0] prev_hi, input logic [31:0] prev_lo,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        Src1 = a; Src2 = b; MDOP = op; Start = 1'b1;
        tick();
        Start = 1'b0; MDOP = 4'd0;
        Src1 = $urandom; Src2 = $urandom;
        chk({tag, "_busy0"}, {31'd0, Busy}, 32'd1);
        chk({tag, "_hi_hold"}, HI, prev_hi);
        chk({tag, "_lo_hold"}, LO, prev_lo);
        for (int i = 1; i < n; i++) begin
            tick();
            chk({tag, "_busy"}, {31'd0, Busy}, 32'd1);
            chk({tag, "_hi_hold"}, HI, prev_hi);
            chk({tag, "_lo_hold"}, LO, prev_lo);
        end
        tick();
        chk({tag, "_busy_end"}, {31'd0, Busy}, 32'd0);
        chk({tag, "_hi"}, HI, exp_hi);
        chk({tag, "_lo"}, LO, exp_lo);
    endtask

    initial begin
        reset = 1'b1; Src1 = '0; Src2 = '0; MDOP = '0; Start = 1'b0; Flush = 1'b0;
        #1;
        tick(); tick();
        reset = 1'b0;
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);
        chk("reset_busy", {31'd0, Busy}, 32'd0);

        // multu 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
        run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'd0, 32'd0, 32'h0000_0001, 32'hFFFF_FFFE);
        // mult -1 * 2 = -2
        run_op("mult", 4'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE,
               32'hFFFF_FFFF, 32'hFFFF_FFFE);
        // div -7 / 2 = -3 rem -1
        run_op("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
        // div overflow case
        run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
               32'd0, 32'h8000_0000);

        // mthi / mtlo set up HI=0x11, LO=0x22
        Src1 = 32'h11; MDOP = 4'd5; Start = 1'b1;
        tick();
        chk("mthi_hi", HI, 32'h11);
        chk("mthi_lo_keep", LO, 32'h8000_0000);
        chk("mthi_busy", {31'd0, Busy}, 32'd0);
        Src1 = 32'h22; MDOP = 4'd6;
        tick();
        Start = 1'b0; MDOP = 4'd0;
        chk("mtlo_lo", LO, 32'h22);
        chk("mtlo_hi_keep", HI, 32'h11);

        // divu by zero: full latency, HI/LO untouched
        run_op("divu_zero", 4'd4, 32'd5, 32'd0, 10, 32'h11, 32'h22, 32'h11, 32'h22);

        // divu 100/7 with operand change, ignored mult start, and a flush
        Src1 = 32'd100; Src2 = 32'd7; MDOP = 4'd4; Start = 1'b1;
        tick();                                   // edge 0
        Start = 1'b0; MDOP = 4'd0;
        tick();                                   // edge 1
        Src1 = 32'd999; Src2 = 32'd3;             // cycle 2 operand change
        tick();                                   // edge 2
        Src1 = 32'd3; Src2 = 32'd4; MDOP = 4'd1; Start = 1'b1;  // cycle 3 mult
        tick();                                   // edge 3
        Start = 1'b0; MDOP = 4'd0; Flush = 1'b1;
        chk("divu_busy_e3", {31'd0, Busy}, 32'd1);
        chk("divu_hi_e3", HI, 32'h11);
        tick();                                   // edge 4, flush while running
        Flush = 1'b0;
        chk("divu_busy_flush", {31'd0, Busy}, 32'd1);
        for (int i = 5; i < 10; i++) begin
            tick();
            chk("divu_busy_run", {31'd0, Busy}, 32'd1);
        end
        tick();                                   // edge 10
        chk("divu100_busy_end", {31'd0, Busy}, 32'd0);
        chk("divu100_lo", LO, 32'd14);
        chk("divu100_hi", HI, 32'd2);
        // the ignored mult must not start a second busy period
        tick();
        chk("divu100_no_restart", {31'd0, Busy}, 32'd0);
        chk("divu100_lo_keep", LO, 32'd14);

        // flushed mthi is dropped
        Src1 = 32'hABCD; MDOP = 4'd5; Start = 1'b1; Flush = 1'b1;
        tick();
        chk("mthi_flush_hi", HI, 32'd2);
        chk("mthi_flush_busy", {31'd0, Busy}, 32'd0);
        Flush = 1'b0;
        tick();
        Start = 1'b0;
        chk("mthi_hi_abcd", HI, 32'h0000_ABCD);

        // mfhi / mflo / none on MDOut
        MDOP = 4'd7; #1;
        chk("mfhi_out", MDOut, 32'h0000_ABCD);
        MDOP = 4'd8; #1;
        chk("mflo_out", MDOut, 32'd14);
        MDOP = 4'd0; #1;
        chk("none_out", MDOut, 32'd0);

        // reserved opcode with Start is ignored
        Src1 = 32'h5555; MDOP = 4'd9; Start = 1'b1;
        tick();
        Start = 1'b0; MDOP = 4'd0;
        chk("op9_hi", HI, 32'h0000_ABCD);
        chk("op9_lo", LO, 32'd14);
        chk("op9_busy", {31'd0, Busy}, 32'd0);

        // reset in cycle 3 of a mult aborts it
        Src1 = 32'd3; Src2 = 32'd4; MDOP = 4'd1; Start = 1'b1;
        tick();                                   // edge 0
        Start = 1'b0; MDOP = 4'd0;
        tick(); tick();                           // edges 1,2
        reset = 1'b1;
        tick();                                   // edge 3
        reset = 1'b0;
        chk("rst_mid_hi", HI, 32'd0);
        chk("rst_mid_lo", LO, 32'd0);
        chk("rst_mid_busy", {31'd0, Busy}, 32'd0);
        // new mult -3 * 5 = -15 right after
        run_op("mult_after_rst", 4'd1, 32'hFFFF_FFFD, 32'd5, 5, 32'd0, 32'd0,
               32'hFFFF_FFFF, 32'hFFFF_FFF1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
